dac_config_scheduler: RTL and testbench

- Holds host-written configuration for the eight DAC output channels and the shared HPF/software-reference settings in a shadow bank.
- Copies the whole bank atomically into the active bank at a safe frame boundary, so no DAC ever sees a mid-frame mix of old and new settings.
- Emits per-DAC HPF-state clear pulses whenever a filter-relevant setting changes.
- Sits between the host wire-in decode logic (dataclk domain) and the eight DAC output instances.

---
 rtl/dac_config_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_dac_config_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_config_scheduler.sv
// dac_config_scheduler: double-buffered DAC channel configuration.
// The host writes a shadow bank; on request, the whole bank is copied into
// the active bank at the next main-sequencer frame boundary, and HPF state
// clears are pulsed for every DAC whose filter-relevant settings changed.
module dac_config_scheduler #(
    parameter logic [31:0] ms_commit = 32'd99,
    parameter int          NUM_DAC   = 8
) (
    input  logic         dataclk,
    input  logic         reset,
    input  logic [31:0]  main_state,
    input  logic         cfg_wr_en,
    input  logic [5:0]   cfg_addr,
    input  logic [15:0]  cfg_data,
    input  logic         commit_req,
    output logic         commit_pending,
    output logic         commit_ack,
    output logic         shadow_dirty,
    output logic [7:0]   DAC_en,
    output logic [23:0]  DAC_gain,
    output logic [55:0]  DAC_noise_suppress,
    output logic [127:0] DAC_thrsh,
    output logic [7:0]   DAC_thrsh_pol,
    output logic [39:0]  DAC_stream_sel,
    output logic [47:0]  DAC_channel_sel,
    output logic [15:0]  HPF_coefficient,
    output logic         HPF_en,
    output logic         software_reference_mode,
    output logic [7:0]   HPF_clear
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic        en;
        logic        pol;
        logic [2:0]  gain;
        logic [6:0]  noise;
        logic [15:0] thrsh;
        logic [4:0]  stream;
        logic [5:0]  channel;
    } dac_cfg_t;

    typedef struct packed {
        logic [15:0] coef;
        logic        hpf_en;
        logic        sw_ref;
    } shared_cfg_t;

    localparam dac_cfg_t DAC_CFG_RST = '{
        en: 1'b0, pol: 1'b0, gain: 3'd0, noise: 7'd0,
        thrsh: 16'h8000, stream: 5'd0, channel: 6'd0
    };
    localparam shared_cfg_t SHARED_CFG_RST = '{coef: 16'h0000, hpf_en: 1'b0, sw_ref: 1'b0};

    state_t      state_q, state_d;
    logic        at_commit_q, at_commit_d;
    dac_cfg_t    shadow_q [NUM_DAC];
    dac_cfg_t    shadow_d [NUM_DAC];
    dac_cfg_t    active_q [NUM_DAC];
    dac_cfg_t    active_d [NUM_DAC];
    shared_cfg_t shared_sh_q, shared_sh_d;
    shared_cfg_t shared_ac_q, shared_ac_d;
    logic        commit_ack_q, commit_ack_d;
    logic [7:0]  hpf_clear_q, hpf_clear_d;
    logic        shadow_dirty_q, shadow_dirty_d;
    logic        boundary;
    logic        cfg_hit;

    // Frame boundary: first cycle main_state sits in ms_commit after being elsewhere.
    always_comb begin
        at_commit_d = (main_state == ms_commit);
        boundary    = at_commit_d && !at_commit_q;
    end

    // Commit sequencing; on the COMMIT cycle the shadow bank is snapshotted.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        commit_ack_d = 1'b0;
        hpf_clear_d  = '0;
        active_d     = active_q;
        shared_ac_d  = shared_ac_q;
        case (state_q)
            IDLE:    if (commit_req) state_d = PENDING;
            PENDING: if (boundary)   state_d = COMMIT;
            COMMIT: begin
                state_d      = IDLE;
                commit_ack_d = 1'b1;
                active_d     = shadow_q;
                shared_ac_d  = shared_sh_q;
                for (int k = 0; k < NUM_DAC; k++) begin
                    hpf_clear_d[k] = (shadow_q[k].stream  != active_q[k].stream) ||
                                     (shadow_q[k].channel != active_q[k].channel);
                end
                // A shared filter setting change invalidates every channel's filter state.
                if (shared_sh_q != shared_ac_q) hpf_clear_d = 8'hFF;
            end
            default: state_d = IDLE;
        endcase
    end

    // Host writes into the shadow bank; a write on the COMMIT cycle lands after the copy.
    always_comb begin
        shadow_d       = shadow_q;
        shared_sh_d    = shared_sh_q;
        shadow_dirty_d = shadow_dirty_q;
        cfg_hit        = 1'b0;
        if (state_q == COMMIT) shadow_dirty_d = 1'b0;
        if (cfg_wr_en) begin
            case (cfg_addr[2:0])
                3'd0: begin
                    shadow_d[cfg_addr[5:3]].en    = cfg_data[11];
                    shadow_d[cfg_addr[5:3]].pol   = cfg_data[10];
                    shadow_d[cfg_addr[5:3]].gain  = cfg_data[9:7];
                    shadow_d[cfg_addr[5:3]].noise = cfg_data[6:0];
                    cfg_hit = 1'b1;
                end
                3'd1: begin
                    shadow_d[cfg_addr[5:3]].thrsh = cfg_data;
                    cfg_hit = 1'b1;
                end
                3'd2: begin
                    shadow_d[cfg_addr[5:3]].stream  = cfg_data[10:6];
                    shadow_d[cfg_addr[5:3]].channel = cfg_data[5:0];
                    cfg_hit = 1'b1;
                end
                3'd7: begin
                    if (cfg_addr[5:3] == 3'd0) begin
                        shared_sh_d.coef = cfg_data;
                        cfg_hit = 1'b1;
                    end else if (cfg_addr[5:3] == 3'd1) begin
                        shared_sh_d.hpf_en = cfg_data[1];
                        shared_sh_d.sw_ref = cfg_data[0];
                        cfg_hit = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (cfg_hit) shadow_dirty_d = 1'b1;
    end

    // State and both configuration banks.
    always_ff @(posedge dataclk) begin
        // NOTE: both banks are architectural registers with defined power-on values, so they are
        // reset explicitly rather than left to power up random like a RAM.
        if (reset) begin
            state_q        <= IDLE;
            at_commit_q    <= 1'b0;
            shared_sh_q    <= SHARED_CFG_RST;
            shared_ac_q    <= SHARED_CFG_RST;
            commit_ack_q   <= 1'b0;
            hpf_clear_q    <= '0;
            shadow_dirty_q <= 1'b0;
            for (int k = 0; k < NUM_DAC; k++) begin
                shadow_q[k] <= DAC_CFG_RST;
                active_q[k] <= DAC_CFG_RST;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            at_commit_q    <= at_commit_d;
            shared_sh_q    <= shared_sh_d;
            shared_ac_q    <= shared_ac_d;
            commit_ack_q   <= commit_ack_d;
            hpf_clear_q    <= hpf_clear_d;
            shadow_dirty_q <= shadow_dirty_d;
            for (int k = 0; k < NUM_DAC; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
        end
    end

    // Flatten the active bank onto the per-DAC output buses.
    always_comb begin
        DAC_en             = '0;
        DAC_gain           = '0;
        DAC_noise_suppress = '0;
        DAC_thrsh          = '0;
        DAC_thrsh_pol      = '0;
        DAC_stream_sel     = '0;
        DAC_channel_sel    = '0;
        for (int k = 0; k < NUM_DAC; k++) begin
            DAC_en[k]                  = active_q[k].en;
            DAC_thrsh_pol[k]           = active_q[k].pol;
            DAC_gain[3*k +: 3]         = active_q[k].gain;
            DAC_noise_suppress[7*k +: 7] = active_q[k].noise;
            DAC_thrsh[16*k +: 16]      = active_q[k].thrsh;
            DAC_stream_sel[5*k +: 5]   = active_q[k].stream;
            DAC_channel_sel[6*k +: 6]  = active_q[k].channel;
        end
    end

    assign HPF_coefficient         = shared_ac_q.coef;
    assign HPF_en                  = shared_ac_q.hpf_en;
    assign software_reference_mode = shared_ac_q.sw_ref;
    assign HPF_clear               = hpf_clear_q;
    assign commit_ack              = commit_ack_q;
    assign commit_pending          = (state_q == PENDING);
    assign shadow_dirty            = shadow_dirty_q;

endmodule

// File: tb/tb_dac_config_scheduler.sv
// Testbench for dac_config_scheduler: directed scenarios plus random traffic,
// every cycle compared against a word-level model of the two register banks.
module tb_dac_config_scheduler;

    logic         dataclk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  main_state = 32'd0;
    logic         cfg_wr_en = 1'b0;
    logic [5:0]   cfg_addr = 6'd0;
    logic [15:0]  cfg_data = 16'd0;
    logic         commit_req = 1'b0;
    logic         commit_pending, commit_ack, shadow_dirty;
    logic [7:0]   DAC_en, DAC_thrsh_pol, HPF_clear;
    logic [23:0]  DAC_gain;
    logic [55:0]  DAC_noise_suppress;
    logic [127:0] DAC_thrsh;
    logic [39:0]  DAC_stream_sel;
    logic [47:0]  DAC_channel_sel;
    logic [15:0]  HPF_coefficient;
    logic         HPF_en, software_reference_mode;

    always #5 dataclk = ~dataclk;

    dac_config_scheduler #(.ms_commit(32'd99), .NUM_DAC(8)) dut (
        .dataclk(dataclk), .reset(reset), .main_state(main_state),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .commit_req(commit_req), .commit_pending(commit_pending),
        .commit_ack(commit_ack), .shadow_dirty(shadow_dirty),
        .DAC_en(DAC_en), .DAC_gain(DAC_gain), .DAC_noise_suppress(DAC_noise_suppress),
        .DAC_thrsh(DAC_thrsh), .DAC_thrsh_pol(DAC_thrsh_pol),
        .DAC_stream_sel(DAC_stream_sel), .DAC_channel_sel(DAC_channel_sel),
        .HPF_coefficient(HPF_coefficient), .HPF_en(HPF_en),
        .software_reference_mode(software_reference_mode), .HPF_clear(HPF_clear)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: raw 16-bit words indexed directly by cfg_addr.
    logic [15:0] m_shadow [64];
    logic [15:0] m_active [64];
    bit          m_prev99, m_pending, m_apply_next;
    bit          e_ack, e_dirty;
    logic [7:0]  e_clear;

    function automatic bit valid_addr(input logic [5:0] a);
        return (a[2:0] <= 3'd2) || (a[2:0] == 3'd7 && a[5:3] <= 3'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_shadow[i] = (i % 8 == 1) ? 16'h8000 : 16'h0000;
            m_active[i] = m_shadow[i];
        end
        m_prev99 = 0; m_pending = 0; m_apply_next = 0;
        e_ack = 0; e_dirty = 0; e_clear = 8'h00;
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_step();
        bit boundary;
        logic [15:0] ws, wa;
        if (reset) begin
            model_reset();
            return;
        end
        e_ack   = m_apply_next;
        e_clear = 8'h00;
        if (m_apply_next) begin
            for (int d = 0; d < 8; d++) begin
                ws = m_shadow[d*8+2];
                wa = m_active[d*8+2];
                if (ws[10:0] != wa[10:0]) e_clear[d] = 1'b1;
            end
            ws = m_shadow[15];
            wa = m_active[15];
            if (m_shadow[7] != m_active[7] || ws[1:0] != wa[1:0]) e_clear = 8'hFF;
            for (int i = 0; i < 64; i++) m_active[i] = m_shadow[i];
            e_dirty = 0;
        end
        if (cfg_wr_en && valid_addr(cfg_addr)) begin
            m_shadow[cfg_addr] = cfg_data;
            e_dirty = 1;
        end
        boundary = (main_state == 32'd99) && !m_prev99;
        m_prev99 = (main_state == 32'd99);
        if (m_apply_next) m_apply_next = 0;
        else if (m_pending) begin
            if (boundary) begin
                m_pending    = 0;
                m_apply_next = 1;
            end
        end else if (commit_req) m_pending = 1;
    endtask

    task automatic check_all();
        logic [7:0]   x_en, x_pol;
        logic [23:0]  x_gain;
        logic [55:0]  x_noise;
        logic [127:0] x_thrsh;
        logic [39:0]  x_stream;
        logic [47:0]  x_chan;
        logic [15:0]  w0, w2, wsh;
        for (int d = 0; d < 8; d++) begin
            w0 = m_active[d*8+0];
            w2 = m_active[d*8+2];
            x_en[d]           = w0[11];
            x_pol[d]          = w0[10];
            x_gain[3*d +: 3]  = w0[9:7];
            x_noise[7*d +: 7] = w0[6:0];
            x_thrsh[16*d +: 16] = m_active[d*8+1];
            x_stream[5*d +: 5] = w2[10:6];
            x_chan[6*d +: 6]   = w2[5:0];
        end
        wsh = m_active[15];
        check("en", DAC_en, x_en);
        check("pol", DAC_thrsh_pol, x_pol);
        check("gain", DAC_gain, x_gain);
        check("noise", DAC_noise_suppress, x_noise);
        check("thrsh", DAC_thrsh, x_thrsh);
        check("stream", DAC_stream_sel, x_stream);
        check("channel", DAC_channel_sel, x_chan);
        check("hpf_coef", HPF_coefficient, m_active[7]);
        check("hpf_en", HPF_en, wsh[1]);
        check("sw_ref", software_reference_mode, wsh[0]);
        check("hpf_clear", HPF_clear, e_clear);
        check("pending", commit_pending, m_pending);
        check("ack", commit_ack, e_ack);
        check("dirty", shadow_dirty, e_dirty);
    endtask

    task automatic tick();
        @(posedge dataclk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_write(input logic [5:0] a, input logic [15:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic pulse_req();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    // Leave ms_commit, request, then re-enter: outputs update after the second edge at 99.
    task automatic commit_now();
        main_state = 32'd50;
        tick();
        pulse_req();
        tick();
        main_state = 32'd99;
        tick();
        tick();
    endtask

    int ack_seen;
    int r;

    initial begin
        model_reset();
        // Reset state.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_thrsh_all", DAC_thrsh, {8{16'h8000}});
        check("rst_en", DAC_en, 8'h00);

        // First commit: DAC3 field0.
        main_state = 32'd50;
        do_write({3'd3, 3'd0}, 16'h0A85);
        pulse_req();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("s2_pending_hold", commit_pending, 1'b1);
            check("s2_en_unchanged", DAC_en, 8'h00);
        end
        main_state = 32'd99;
        tick();
        check("s2_not_yet", DAC_en[3], 1'b0);
        tick();
        check("s2_en3", DAC_en[3], 1'b1);
        check("s2_gain3", DAC_gain[11:9], 3'd5);
        check("s2_noise3", DAC_noise_suppress[27:21], 7'h05);
        check("s2_ack", commit_ack, 1'b1);
        check("s2_clear", HPF_clear, 8'h00);
        tick();
        check("s2_ack_once", commit_ack, 1'b0);

        // Stream/channel change on DAC5 clears only DAC5.
        main_state = 32'd50;
        do_write({3'd5, 3'd2}, 16'h00D1);
        commit_now();
        check("s3_clear5", HPF_clear, 8'b0010_0000);
        check("s3_stream5", DAC_stream_sel[29:25], 5'd3);
        check("s3_chan5", DAC_channel_sel[35:30], 6'd17);
        tick();
        check("s3_clear_once", HPF_clear, 8'h00);
        do_write({3'd0, 3'd7}, 16'h0123);
        commit_now();
        check("s3_clear_all", HPF_clear, 8'hFF);
        check("s3_coef", HPF_coefficient, 16'h0123);

        // Request while parked in ms_commit: no boundary until re-entry.
        do_write({3'd2, 3'd1}, 16'h5555);
        main_state = 32'd99;
        ack_seen = 0;
        for (int i = 0; i < 10; i++) begin
            commit_req = (i == 5);
            tick();
            if (commit_ack) ack_seen++;
        end
        commit_req = 1'b0;
        check("s4_no_ack", ack_seen, 0);
        check("s4_pending", commit_pending, 1'b1);
        main_state = 32'd50;
        tick();
        main_state = 32'd99;
        tick();
        tick();
        check("s4_ack", commit_ack, 1'b1);
        check("s4_thrsh2", DAC_thrsh[47:32], 16'h5555);

        // Write on the COMMIT cycle misses the copy.
        main_state = 32'd50;
        do_write({3'd4, 3'd0}, 16'h0800);
        tick();
        pulse_req();
        tick();
        main_state = 32'd99;
        tick();
        do_write({3'd0, 3'd1}, 16'h1234);
        check("s5_ack", commit_ack, 1'b1);
        check("s5_thrsh_old", DAC_thrsh[15:0], 16'h8000);
        check("s5_dirty", shadow_dirty, 1'b1);
        commit_now();
        check("s5_thrsh_new", DAC_thrsh[15:0], 16'h1234);

        // Reset while pending.
        main_state = 32'd50;
        do_write({3'd1, 3'd0}, 16'h0FFF);
        pulse_req();
        tick();
        check("s6_pending", commit_pending, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s6_pending_clr", commit_pending, 1'b0);
        main_state = 32'd99;
        ack_seen = 0;
        repeat (4) begin
            tick();
            if (commit_ack) ack_seen++;
        end
        check("s6_no_ack", ack_seen, 0);
        check("s6_thrsh_rst", DAC_thrsh, {8{16'h8000}});
        check("s6_en_rst", DAC_en, 8'h00);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            cfg_wr_en  = ($urandom_range(0, 2) == 0);
            cfg_addr   = 6'($urandom);
            cfg_data   = 16'($urandom);
            commit_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 2);
                if (r == 0) main_state = 32'd99;
                else if (r == 1) main_state = 32'd50;
                else main_state = $urandom;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
